// File: rtl/nios2_oci_dct_packer.sv
// Packs 2-bit direct-branch trace symbols into 30-bit records (up to 15 symbols)
// behind a valid/ready output stage, and runs the end-of-test drain handshake.
module nios2_oci_dct_packer #(
  parameter int SEAL_TIMEOUT = 64,
  parameter int MAX_SYMS     = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        br_valid,
  input  logic [1:0]  br_code,
  output logic        br_ready,
  input  logic        flush,
  input  logic        end_req,
  output logic        dct_valid,
  input  logic        dct_ready,
  output logic [29:0] dct_buffer,
  output logic [3:0]  dct_count,
  output logic        test_ending,
  output logic        test_has_ended,
  output logic [1:0]  dbg_state
);

  // Handshakes: a beat moves on a rising edge where valid && ready; valid never
  // depends on ready, and an offered record holds its data until it is taken.

  localparam int IW = (SEAL_TIMEOUT > 0) ? $clog2(SEAL_TIMEOUT + 1) : 1;
  localparam logic [IW-1:0] TMO = IW'(SEAL_TIMEOUT);
  // MAX_SYMS must stay 15: the 30-bit buffer holds exactly fifteen symbols.
  localparam logic [3:0] FULL = 4'(MAX_SYMS);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    ENDING = 2'd2,
    ENDED  = 2'd3
  } end_state_t;

  end_state_t state;

  logic          live;
  logic          flush_pending;
  logic          end_pending;
  logic [29:0]   acc_buf;
  logic [3:0]    acc_cnt;
  logic [IW-1:0] idle_cnt;

  logic          acc_full;
  logic          timeout_hit;
  logic          seal;
  logic          xfer;
  logic          accept;
  logic          flush_req;
  logic [29:0]   base_buf;
  logic [3:0]    base_cnt;
  logic [29:0]   next_buf;
  logic [3:0]    next_cnt;

  assign dbg_state = state;

  always_comb begin
    acc_full    = (acc_cnt == FULL);
    timeout_hit = (SEAL_TIMEOUT != 0) && (idle_cnt == TMO);
    seal        = acc_full || ((acc_cnt != 4'd0) && (flush_pending || timeout_hit));
    xfer        = seal && (!dct_valid || dct_ready);
    br_ready    = live && !test_has_ended && !end_pending && !(acc_full && !xfer);
    accept      = br_valid && br_ready;
    flush_req   = (flush || (end_req && state == RUN)) && (state == RUN || state == DRAIN);
    // A transfer empties the accumulator first, so a symbol taken in the same
    // cycle starts the next record instead of being merged into the sealed one.
    base_buf    = xfer ? 30'd0 : acc_buf;
    base_cnt    = xfer ? 4'd0 : acc_cnt;
    next_buf    = accept ? {base_buf[27:0], br_code} : base_buf;
    next_cnt    = accept ? base_cnt + 4'd1 : base_cnt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      live          <= 1'b0;
      acc_buf       <= 30'd0;
      acc_cnt       <= 4'd0;
      idle_cnt      <= '0;
      flush_pending <= 1'b0;
      dct_valid     <= 1'b0;
      dct_buffer    <= 30'd0;
      dct_count     <= 4'd0;
    end else begin
      live    <= 1'b1;
      acc_buf <= next_buf;
      acc_cnt <= next_cnt;

      if (accept || xfer) begin
        idle_cnt <= '0;
      end else if ((SEAL_TIMEOUT != 0) && (acc_cnt != 4'd0) && (idle_cnt != TMO)) begin
        idle_cnt <= idle_cnt + 1'b1;
      end

      // A flush against an empty accumulator is dropped on the spot.
      if (flush_req) begin
        flush_pending <= (next_cnt != 4'd0);
      end else begin
        flush_pending <= flush_pending && !xfer && (acc_cnt != 4'd0);
      end

      if (xfer) begin
        dct_valid  <= 1'b1;
        dct_buffer <= acc_buf;
        dct_count  <= acc_cnt;
      end else if (dct_ready) begin
        dct_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= RUN;
      end_pending    <= 1'b0;
      test_ending    <= 1'b0;
      test_has_ended <= 1'b0;
    end else begin
      test_ending <= 1'b0;
      case (state)
        RUN: begin
          if (end_req) begin
            end_pending <= 1'b1;
            state       <= DRAIN;
          end
        end
        DRAIN: begin
          if ((acc_cnt == 4'd0) && !dct_valid) begin
            test_ending <= 1'b1;
            state       <= ENDING;
          end
        end
        ENDING: begin
          test_has_ended <= 1'b1;
          state          <= ENDED;
        end
        ENDED: begin
          state <= ENDED;
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

endmodule
